// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions. The display encoder and the capture decoder
// both use this table, so the two ends of the path always agree.
package seg7_pkg;

  // Segment patterns are ordered a..g from left to right and are active-low.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] SEG_CODE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } cap_state_e;

  // Returns {valid, value}; valid is 0 for blank and for unknown patterns.
  function automatic logic [4:0] seg_to_hex(input logic [0:6] pat);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_CODE[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  // True when the pattern is one of the sixteen hex digits.
  function automatic logic seg_is_code(input logic [0:6] pat);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_CODE[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/seg7_sync.sv
// Two-flop synchroniser for the 7-bit segment bus. Resets to the blank
// pattern so the decoder sees "display off" until real samples arrive.
module seg7_sync
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       aclr,
  input  logic [0:6] d_i,
  output logic [0:6] q_o
);

  logic [0:6] meta_q;
  logic [0:6] sync_q;

  // Metastability filter; keeps running regardless of the decoder's enable.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      meta_q <= SEG_BLANK;
      sync_q <= SEG_BLANK;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seg7_capture_decoder.sv
// Receive-side monitor for a 7-segment display: synchronises and debounces
// the segment bus, decodes committed patterns and checks that the digits
// follow a mod-16 up-count.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [0:6]       seg,
  input  logic             en,
  output logic [3:0]       digit,
  output logic             digit_vld,
  output logic             new_digit,
  output logic             blank,
  output logic             bad_pat,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  STAB_MAX = CNT_W'(STABLE_CYCLES);

  logic [0:6]       seg_s;
  logic [0:6]       cand_q, cand_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [0:6]       comm_q, comm_d;
  cap_state_e       state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             commit;
  logic [4:0]       cand_dec;
  logic             cand_ok;
  logic [3:0]       cand_val;

  seg7_sync u_sync (
    .clk  (clk),
    .aclr (aclr),
    .d_i  (seg),
    .q_o  (seg_s)
  );

  // Debounce: count consecutive identical samples, restart on any change.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (en) begin
      if (seg_s == cand_q) begin
        if (stab_q != STAB_MAX) stab_d = stab_q + CNT_W'(1);
      end else begin
        cand_d = seg_s;
        stab_d = CNT_W'(1);
      end
    end
  end

  // A settled pattern is only a commit when it differs from the one on record.
  assign commit   = en && (stab_q == STAB_MAX) && (cand_q != comm_q);
  assign cand_dec = seg_to_hex(cand_q);
  assign cand_ok  = cand_dec[4];
  assign cand_val = cand_dec[3:0];

  // Tracking FSM and sequence checker; pulses are raised in the commit cycle.
  always_comb begin
    state_d   = state_q;
    comm_d    = comm_q;
    digit_d   = digit_q;
    err_d     = err_q;
    new_digit = 1'b0;
    seq_err   = 1'b0;
    if (commit) begin
      comm_d = cand_q;
      if (cand_ok) begin
        state_d   = ST_LOCKED;
        digit_d   = cand_val;
        new_digit = 1'b1;
        // Only a held reference digit can be checked; 4-bit add gives F->0 wrap.
        if ((state_q == ST_LOCKED) && (cand_val != digit_q + 4'd1)) begin
          seq_err = 1'b1;
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end
      end else if (cand_q == SEG_BLANK) begin
        state_d = ST_EMPTY;
      end else begin
        state_d = ST_FAULT;
      end
    end
  end

  // State registers; a reset mid-settle discards any partial candidate.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      cand_q  <= SEG_BLANK;
      stab_q  <= '0;
      comm_q  <= SEG_BLANK;
      state_q <= ST_EMPTY;
      digit_q <= 4'd0;
      err_q   <= '0;
    end else begin
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      comm_q  <= comm_d;
      state_q <= state_d;
      digit_q <= digit_d;
      err_q   <= err_d;
    end
  end

  assign digit     = digit_q;
  assign digit_vld = (state_q == ST_LOCKED);
  assign blank     = (comm_q == SEG_BLANK);
  assign bad_pat   = !seg_is_code(comm_q) && (comm_q != SEG_BLANK);
  assign err_count = err_q;

endmodule
